// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity selectors, default sizes
// and the 2-of-3 vote used by the oversampling receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned UART_WIDTH       = 8;
    localparam int unsigned UART_PRESCALE_WD = 6;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver configuration and word-output bundle; master drives the line and
// configuration, slave is the receiver.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH       = UART_WIDTH,
    parameter int unsigned PRESCALE_WD = UART_PRESCALE_WD
);
    logic                   RX_IN;
    logic [PRESCALE_WD-1:0] Prescale;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [WIDTH-1:0]       P_DATA;
    logic                   DATA_VALID;
    logic                   PAR_ERR;
    logic                   STP_ERR;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit timing: edge counter, three mid-bit samples and the majority vote.
// Strobes are combinational and qualified by i_en (FSM out of IDLE).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_WD = UART_PRESCALE_WD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [PRESCALE_WD-1:0] i_prescale,
    input  logic                   i_rx,
    output logic                   o_sample_done_c,
    output logic                   o_bit_val_c,
    output logic                   o_bit_end_c
);
    logic [PRESCALE_WD-1:0] r_edge_cnt;
    logic                   r_s0;
    logic                   r_s1;
    logic [PRESCALE_WD-1:0] w_half;
    logic [PRESCALE_WD-1:0] w_last;

    assign w_half = i_prescale >> 1;
    assign w_last = i_prescale - PRESCALE_WD'(1);

    // Counter parks at zero while idle so every frame starts aligned to its start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
        end else begin
            if (!i_en)
                r_edge_cnt <= '0;
            else if (r_edge_cnt == w_last)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + PRESCALE_WD'(1);

            if (i_en && (r_edge_cnt == w_half - PRESCALE_WD'(1)))
                r_s0 <= i_rx;
            if (i_en && (r_edge_cnt == w_half))
                r_s1 <= i_rx;
        end
    end

    assign o_sample_done_c = i_en && (r_edge_cnt == w_half + PRESCALE_WD'(1));
    assign o_bit_val_c     = maj3(r_s0, r_s1, i_rx);
    assign o_bit_end_c     = i_en && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first shift register, parity and
// stop checking, registered word/strobe outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH       = UART_WIDTH,
    parameter int unsigned PRESCALE_WD = UART_PRESCALE_WD
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                   r_sync1, r_sync2;
    logic                   w_rx_s;
    rx_state_t              r_state, w_state_nxt;
    logic [PRESCALE_WD-1:0] r_prescale;
    logic                   r_par_en, r_par_typ;
    logic [WIDTH-1:0]       r_shift, w_shift_nxt;
    logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic                   r_par_fail, w_par_fail_nxt;
    logic [WIDTH-1:0]       r_data, w_data_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_par_err, w_par_err_nxt;
    logic                   r_stp_err, w_stp_err_nxt;
    logic                   w_sample_done, w_bit_val, w_bit_end;

    assign w_rx_s = r_sync2;

    uart_rx_sampler #(.PRESCALE_WD(PRESCALE_WD)) u_sampler (
        .clk             (CLK),
        .rst_n           (RST),
        .i_en            (r_state != IDLE),
        .i_prescale      (r_prescale),
        .i_rx            (w_rx_s),
        .o_sample_done_c (w_sample_done),
        .o_bit_val_c     (w_bit_val),
        .o_bit_end_c     (w_bit_end)
    );

    // Configuration tracks the inputs only while idle, so it is frozen for the whole frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_fail <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_sync1    <= bus.RX_IN;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            if (r_state == IDLE) begin
                r_prescale <= bus.Prescale;
                r_par_en   <= bus.PAR_EN;
                r_par_typ  <= bus.PAR_TYP;
            end
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_par_fail <= w_par_fail_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_par_err  <= w_par_err_nxt;
            r_stp_err  <= w_stp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_par_fail_nxt = r_par_fail;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_par_err_nxt  = 1'b0;
        w_stp_err_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt    = START;
                    w_bit_cnt_nxt  = '0;
                    w_par_fail_nxt = 1'b0;
                end
            end
            START: begin
                if (w_sample_done && w_bit_val)
                    w_state_nxt = IDLE;
                else if (w_bit_end)
                    w_state_nxt = DATA;
            end
            DATA: begin
                if (w_sample_done)
                    w_shift_nxt = {w_bit_val, r_shift[WIDTH-1:1]};
                if (w_bit_end) begin
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_sample_done && (((^r_shift) ^ r_par_typ) != w_bit_val))
                    w_par_fail_nxt = 1'b1;
                if (w_bit_end)
                    w_state_nxt = STOP;
            end
            STOP: begin
                // Leave at mid-stop-bit so an immediately following start edge is caught
                if (w_sample_done) begin
                    w_state_nxt   = IDLE;
                    w_stp_err_nxt = !w_bit_val;
                    w_par_err_nxt = r_par_fail;
                    if (w_bit_val && !r_par_fail) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.P_DATA     = r_data;
    assign bus.DATA_VALID = r_valid;
    assign bus.PAR_ERR    = r_par_err;
    assign bus.STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialized from a bit list, the
// expected word/flags/arrival cycle are queued, and a monitor checks each output pulse.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 6;

    typedef struct {
        logic [W-1:0] data;
        logic         valid;
        logic         perr;
        logic         serr;
        int unsigned  cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [W-1:0] last_good = '0;
    exp_t        q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx_if #(.WIDTH(W), .PRESCALE_WD(PW)) bus ();

    uart_rx #(.WIDTH(W), .PRESCALE_WD(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse consumes one scoreboard entry
    always @(negedge CLK) begin
        if (RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("p_data",     32'(bus.P_DATA),     32'(e.data));
                chk("data_valid", 32'(bus.DATA_VALID), 32'(e.valid));
                chk("par_err",    32'(bus.PAR_ERR),    32'(e.perr));
                chk("stp_err",    32'(bus.STP_ERR),    32'(e.serr));
                chk("arrival_cycle", cyc, e.cyc);
            end
        end
    end

    // Serialize one frame; corrupt_bit >= 0 flips one mid-bit cycle of that data bit
    task automatic send_frame(input logic [W-1:0] d, input int p, input logic pe,
                              input logic pt, input logic flip, input logic stop_ok,
                              input int gap, input int corrupt_bit);
        logic bits[$];
        exp_t e;
        bus.Prescale = PW'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(W); i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt ^ flip);
        bits.push_back(stop_ok);
        e.perr  = pe & flip;
        e.serr  = !stop_ok;
        e.valid = !(e.perr || e.serr);
        if (e.valid) last_good = d;
        e.data  = last_good;
        e.cyc   = cyc + 1 + 2 + int'(p) * (1 + int'(W) + int'(pe)) + int'(p) / 2 + 2;
        q.push_back(e);
        for (int k = 0; k < bits.size(); k++) begin
            for (int j = 0; j < p; j++) begin
                if (corrupt_bit >= 0 && k == corrupt_bit + 1 && j == p / 2 + 1)
                    bus.RX_IN = ~bits[k];
                else
                    bus.RX_IN = bits[k];
                @(negedge CLK);
            end
        end
        bus.RX_IN = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", q.size(), 32'd0);
        repeat (4) @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_p_data"},     32'(bus.P_DATA),     32'd0);
        chk({tag, "_data_valid"}, 32'(bus.DATA_VALID), 32'd0);
        chk({tag, "_par_err"},    32'(bus.PAR_ERR),    32'd0);
        chk({tag, "_stp_err"},    32'(bus.STP_ERR),    32'd0);
    endtask

    initial begin
        int plist[6];
        plist = '{6, 8, 10, 12, 16, 32};
        bus.RX_IN    = 1'b1;
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = PAR_EVEN;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        send_frame(8'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, -1);
        drain();

        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 16, -1);
        send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 16, -1);
        drain();

        send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 16, -1);
        send_frame(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, -1);
        drain();

        // Short low glitch on an idle line must be rejected silently
        bus.Prescale = PW'(16);
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        bus.RX_IN    = 1'b1;
        repeat (48) @(negedge CLK);
        send_frame(8'hF0, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 16, 3);
        drain();

        send_frame(8'h00, 32, 1'b1, PAR_ODD, 1'b0, 1'b1, 0, -1);
        send_frame(8'hFF, 32, 1'b1, PAR_ODD, 1'b0, 1'b1, 0, -1);
        send_frame(8'h12, 32, 1'b1, PAR_ODD, 1'b0, 1'b1, 0, -1);
        drain();

        // Reset in the middle of a frame (start bit plus two zero data bits)
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (24) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("midframe_reset");
        bus.RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        last_good = '0;
        repeat (4) @(negedge CLK);
        send_frame(8'h6B, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8, -1);
        drain();

        // Randomized frames with random configuration and error injection
        for (int n = 0; n < 12; n++) begin
            int   p;
            logic pe, pt, flip, stop_ok;
            int   gap, cb;
            p       = plist[$urandom_range(0, 5)];
            pe      = 1'($urandom_range(0, 1));
            pt      = 1'($urandom_range(0, 1));
            flip    = pe & ($urandom_range(0, 3) == 0);
            stop_ok = ($urandom_range(0, 3) != 0);
            gap     = stop_ok ? int'($urandom_range(0, 3)) : p + 4;
            cb      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            send_frame(8'($urandom), p, pe, pt, flip, stop_ok, gap, cb);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
